// File: rtl/ff_pkg.sv
// Shared mode encoding for the universal register bank.
// Imported by ff_bank_univ and its bench.
package ff_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_LOAD = 3'd1;
  localparam mode_t MODE_TOGL = 3'd2;
  localparam mode_t MODE_SHL  = 3'd3;
  localparam mode_t MODE_SHR  = 3'd4;
  localparam mode_t MODE_ROTL = 3'd5;
  localparam mode_t MODE_INC  = 3'd6;
  localparam mode_t MODE_DEC  = 3'd7;

endpackage

// File: rtl/ff_bank_univ.sv
// WIDTH-bit multi-mode register: load, toggle, shift, rotate, inc/dec.
// Synchronous clear/set, enable, terminal count and sticky wrap flag.
module ff_bank_univ
  import ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             set,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] t,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             ovf_q;

  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_HOLD: q_d = q_q;
      MODE_LOAD: q_d = d;
      MODE_TOGL: q_d = q_q ^ t;
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin};
      MODE_SHR:  q_d = {sin, q_q[WIDTH-1:1]};
      MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_INC:  q_d = q_q + 1'b1;
      MODE_DEC:  q_d = q_q - 1'b1;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   q_q <= RST_VAL;
    else if (clr) q_q <= RST_VAL;
    else if (set) q_q <= SET_VAL;
    else if (en)  q_q <= q_d;
  end

  // set leaves the flag alone; only a real wrap raises it
  always_ff @(posedge clk) begin
    if (!rst_n || clr)   ovf_q <= 1'b0;
    else if (!set && tc) ovf_q <= 1'b1;
  end

  assign q    = q_q;
  assign qbar = ~q_q;
  assign ovf  = ovf_q;

  assign sout = (mode == MODE_SHL || mode == MODE_ROTL) ? q_q[WIDTH-1]
              : (mode == MODE_SHR)                      ? q_q[0]
              : 1'b0;

  assign tc = en & (((mode == MODE_INC) & (&q_q)) |
                    ((mode == MODE_DEC) & ~(|q_q)));

endmodule
